uart_tx_serialiser: RTL
=======================

Name: uart_tx_serialiser

Overview:
UART transmitter that drains bytes from an upstream sync_fifo (DEPTH/WIDTH=8 instance) via its r_data/empty/r_en interface and serialises them onto a single tx line. It is the direct downstream consumer of the TX FIFO in the UART peripheral. Frame format is 8N1 by default, with optional parity and a second stop bit. Bit timing comes from a programmable integer clock divider.

Parameters:
W_DIV, 16, width of clkdiv; one bit period = clkdiv clk cycles (clkdiv==0 treated as 1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active-low
enable  input  1  permit starting new frames; an in-flight frame always completes
clkdiv  input  W_DIV  clk cycles per bit period
parity_en  input  1  insert parity bit after data
parity_odd  input  1  1 = odd parity, 0 = even
stop2  input  1  1 = two stop bits, 0 = one
fifo_rdata  input  8  head of upstream FIFO, valid while !fifo_empty
fifo_empty  input  1  upstream FIFO empty flag
fifo_ren  output  1  pop strobe to upstream FIFO
tx  output  1  serial line, idle high
busy  output  1  frame in progress

Behaviour:
- Reset: tx=1, busy=0, fifo_ren=0, state IDLE, counters 0. Reset mid-frame aborts immediately; tx returns high asynchronously.
- fifo_ren is combinational and strictly equals (launch condition) below; it is never asserted while fifo_empty=1, so no pop-on-empty.
- Launch condition: enable && !fifo_empty && (state==IDLE || (last cycle of last stop bit)).
- Launch cycle N: fifo_ren=1; fifo_rdata captured into 8-bit shift register; clkdiv, parity_en, parity_odd, stop2 latched for the whole frame. Parity computed from captured byte (even: XOR of bits; odd: inverted).
- States: IDLE -> START -> DATA (8 bits, LSB first) -> PARITY (only if latched parity_en) -> STOP (1 or 2 bits) -> IDLE, or -> START directly on launch.
- START begins cycle N+1: tx=0 for exactly clkdiv cycles; every subsequent bit likewise exactly clkdiv cycles.
- Frame length = (10 + parity_en + stop2) * clkdiv cycles from N+1; back-to-back frames have zero idle gap (new start bit in the cycle after final stop cycle).
- tx is registered; no glitches.
- busy=1 from cycle N+1 through the final stop cycle; falls to 0 only when entering IDLE (stays 1 across back-to-back frames).
- Bit counter: 3 bits for data index; divider counter W_DIV bits, loads latched clkdiv-1 at each bit start, bit advances when it reaches 0.
- enable deasserted mid-frame: frame completes normally, no further launch. Config changes mid-frame: ignored until next launch.
- fifo_rdata changing while not popping: ignored (captured only on launch).
- clkdiv==1: one bit per clk cycle, launch still pipelines correctly (10-cycle 8N1 frames continuous).

Decomposition:
- Package uart_pkg: state encoding (IDLE, START, DATA, PARITY, STOP), DATA_BITS=8 constant, frame-length helper function for the bench.
- One sub-module natural: uart_bit_timer (loadable down-counter, W_DIV wide, outputs bit_end strobe on the last cycle of each bit period); FSM + shift register stay in top.

Test Plan:
- Reset, FIFO empty, enable=1 -> tx=1, busy=0, fifo_ren never asserted for 1000 cycles.
- clkdiv=4, 8N1, push 0xA5 -> one fifo_ren pulse; tx = 0,1,0,1,0,0,1,0,1,1 each held 4 cycles (40 cycles), then busy=0.
- clkdiv=3, parity_en=1 parity_odd=0 stop2=1, byte 0x07 -> start, data 1,1,1,0,0,0,0,0, parity 1, two stop 1s; 12*3=36 cycles.
- clkdiv=1, FIFO preloaded with 0x00,0xFF,0x55 -> three pops exactly 10 cycles apart, continuous 30-cycle tx stream, busy high throughout, no gap.
- Deassert enable during data bit 3 of 0x3C with further bytes queued -> current frame completes intact, no further fifo_ren until enable reasserted; change clkdiv 4->8 mid-frame -> bit widths stay 4 until next frame.
- Assert rst_n=0 during data bit 5 -> tx=1, busy=0 immediately; after release, next queued byte sent as full correct frame.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit path: frame state encoding,
// data-bit count and a frame-length helper.
//   uart_state_e  : serialiser FSM states
//   DATA_BITS     : payload bits per frame
//   frame_cycles(): clk cycles one frame occupies on the line
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Start + data + optional parity + one or two stops, each bit lasting
  // clkdiv cycles (a divider of 0 behaves as 1).
  function automatic int unsigned frame_cycles(input logic parity_en,
                                               input logic stop2,
                                               input int unsigned clkdiv);
    int unsigned d;
    d = (clkdiv == 0) ? 1 : clkdiv;
    return (32'd2 + DATA_BITS + int'(parity_en) + int'(stop2)) * d;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer
// Loadable down-counter that measures one bit period.
//   clk, rst_n : clock, async active-low reset
//   run        : a frame is on the line; bit_end is suppressed otherwise
//   load       : reload the counter this cycle (start of the next bit)
//   load_val   : cycles-per-bit minus one
//   bit_end    : high on the last cycle of the current bit period
module uart_bit_timer #(
  parameter int W_DIV = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic [W_DIV-1:0] load_val,
  output logic             bit_end
);

  logic [W_DIV-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // A loaded value of 0 makes every cycle a bit end, which gives the
  // one-bit-per-clock mode without special casing.
  assign bit_end = run && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_serialiser.sv
// uart_tx_serialiser
// Drains bytes from an upstream FIFO and serialises them onto tx as
// start / 8 data (LSB first) / optional parity / 1 or 2 stop bits.
//   clk, rst_n  : clock, async active-low reset
//   enable      : allow new frames to start (a running frame always finishes)
//   clkdiv      : clk cycles per bit (0 behaves as 1)
//   parity_en   : append a parity bit after the data
//   parity_odd  : 1 = odd parity, 0 = even
//   stop2       : 1 = two stop bits
//   fifo_rdata  : FIFO head, valid while !fifo_empty
//   fifo_empty  : FIFO empty flag
//   fifo_ren    : pop strobe, high exactly in the cycle a frame is launched
//   tx          : serial line, idles high, registered
//   busy        : a frame is on the line
module uart_tx_serialiser
  import uart_pkg::*;
#(
  parameter int W_DIV = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [W_DIV-1:0] clkdiv,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             stop2,
  input  logic [7:0]       fifo_rdata,
  input  logic             fifo_empty,
  output logic             fifo_ren,
  output logic             tx,
  output logic             busy
);

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  uart_state_e      state_q, state_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             par_en_q, par_en_d;
  logic             stop2_q, stop2_d;
  logic             stop_idx_q, stop_idx_d;
  logic [W_DIV-1:0] div_m1_q, div_m1_d;
  logic             tx_q, tx_d;

  logic             bit_end;
  logic             last_stop;
  logic             launch;
  logic             tmr_load;
  logic [W_DIV-1:0] tmr_val;
  logic [W_DIV-1:0] div_live_m1;

  // Launch / timer control
  always_comb begin
    div_live_m1 = (clkdiv == '0) ? '0 : clkdiv - 1'b1;
    last_stop   = (state_q == ST_STOP) && bit_end && (!stop2_q || stop_idx_q);
    // rst_n is folded in so no pop can be issued while held in reset.
    launch      = rst_n && enable && !fifo_empty &&
                  ((state_q == ST_IDLE) || last_stop);
    // Every bit boundary reloads the timer; at launch the live divider is
    // used since the latched copy only becomes valid next cycle.
    tmr_load    = launch || bit_end;
    tmr_val     = launch ? div_live_m1 : div_m1_q;
  end

  uart_bit_timer #(.W_DIV(W_DIV)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (state_q != ST_IDLE),
    .load     (tmr_load),
    .load_val (tmr_val),
    .bit_end  (bit_end)
  );

  // Next-state and next tx value. tx_d is the line level for the bit that
  // starts next cycle, so tx is a clean flop output.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;
    div_m1_d   = div_m1_q;
    tx_d       = tx_q;

    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          tx_d      = shreg_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_IDX) begin
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d    = ST_STOP;
              stop_idx_d = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shreg_d   = {1'b0, shreg_q[7:1]};
            tx_d      = shreg_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d    = ST_STOP;
          stop_idx_d = 1'b0;
          tx_d       = 1'b1;
        end
      end
      ST_STOP: begin
        if (last_stop) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end else if (bit_end) begin
          stop_idx_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Launch overrides the stop->idle transition so back-to-back frames
    // run with no idle cycle between them.
    if (launch) begin
      state_d  = ST_START;
      tx_d     = 1'b0;
      shreg_d  = fifo_rdata;
      par_d    = (^fifo_rdata) ^ parity_odd;
      par_en_d = parity_en;
      stop2_d  = stop2;
      div_m1_d = div_live_m1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      div_m1_q   <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      div_m1_q   <= div_m1_d;
      tx_q       <= tx_d;
    end
  end

  assign fifo_ren = launch;
  assign tx       = tx_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
